// File: rtl/text_writer.sv
// Character-stream text writer: turns a byte stream into character RAM writes,
// tracking a cursor and clearing rows/screen with the blank code.
module text_writer #(
    parameter int          C_COLS  = 80,
    parameter int          C_ROWS  = 40,
    parameter logic [7:0]  C_BLANK = 8'h20
) (
    input  logic        R_clk_65M,
    input  logic        rst,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    output logic        R_ram_we,
    output logic [11:0] R_ram_waddr,
    output logic [7:0]  R_ram_wdata,
    output logic [6:0]  cursor_col,
    output logic [5:0]  cursor_row
);

    typedef enum logic [1:0] {
        IDLE,
        CLR_ROW,
        CLR_ALL
    } state_t;

    localparam logic [11:0] LP_COLS     = 12'(C_COLS);
    localparam logic [11:0] LP_TOTAL    = 12'(C_ROWS * C_COLS);
    localparam logic [6:0]  LP_LAST_COL = 7'(C_COLS - 1);
    localparam logic [5:0]  LP_LAST_ROW = 6'(C_ROWS - 1);

    state_t      state_q;
    logic        ready_q;
    logic        we_q;
    logic [11:0] waddr_q;
    logic [7:0]  wdata_q;
    logic [6:0]  col_q;
    logic [5:0]  row_q;
    logic [11:0] clr_q;

    logic [11:0] row_base_d;
    logic [11:0] col_addr_d;
    logic [5:0]  row_next_d;
    logic [11:0] next_base_d;
    logic [11:0] clr_limit_d;
    logic        xfer;
    logic        is_print;
    logic        is_nl;
    logic        is_bs;
    logic        is_ff;

    assign row_base_d  = 12'(row_q) * LP_COLS;
    assign col_addr_d  = row_base_d + 12'(col_q);
    assign row_next_d  = (row_q == LP_LAST_ROW) ? 6'd0 : row_q + 6'd1;
    assign next_base_d = 12'(row_next_d) * LP_COLS;
    // Clear runs one past the last address; that extra cycle is the exit step.
    assign clr_limit_d = (state_q == CLR_ALL) ? LP_TOTAL : row_base_d + LP_COLS;

    assign xfer     = char_valid & ready_q;
    assign is_print = (char_data >= 8'h20) && (char_data <= 8'h7E);
    assign is_nl    = (char_data == 8'h0A) || (char_data == 8'h0D);
    assign is_bs    = (char_data == 8'h08);
    assign is_ff    = (char_data == 8'h0C);

    always_ff @(posedge R_clk_65M or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
            clr_q   <= '0;
        end else begin
            we_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (xfer) begin
                        unique case (1'b1)
                            is_print: begin
                                we_q    <= 1'b1;
                                waddr_q <= col_addr_d;
                                wdata_q <= char_data;
                                if (col_q == LP_LAST_COL) begin
                                    col_q   <= '0;
                                    row_q   <= row_next_d;
                                    clr_q   <= next_base_d;
                                    state_q <= CLR_ROW;
                                    ready_q <= 1'b0;
                                end else begin
                                    col_q <= col_q + 7'd1;
                                end
                            end
                            is_nl: begin
                                col_q   <= '0;
                                row_q   <= row_next_d;
                                clr_q   <= next_base_d;
                                state_q <= CLR_ROW;
                                ready_q <= 1'b0;
                            end
                            is_bs: begin
                                if (col_q != 7'd0) begin
                                    col_q   <= col_q - 7'd1;
                                    we_q    <= 1'b1;
                                    waddr_q <= col_addr_d - 12'd1;
                                    wdata_q <= C_BLANK;
                                end
                            end
                            is_ff: begin
                                col_q   <= '0;
                                row_q   <= '0;
                                clr_q   <= '0;
                                state_q <= CLR_ALL;
                                ready_q <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                CLR_ROW, CLR_ALL: begin
                    if (clr_q == clr_limit_d) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        we_q    <= 1'b1;
                        waddr_q <= clr_q;
                        wdata_q <= C_BLANK;
                        clr_q   <= clr_q + 12'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign char_ready  = ready_q;
    assign R_ram_we    = we_q;
    assign R_ram_waddr = waddr_q;
    assign R_ram_wdata = wdata_q;
    assign cursor_col  = col_q;
    assign cursor_row  = row_q;

endmodule

// File: tb/tb_text_writer.sv
// Directed bench for text_writer: character writes, wrap, newline,
// backspace, clear screen and reset during a clear.
module tb_text_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic        char_ready;
    logic        R_ram_we;
    logic [11:0] R_ram_waddr;
    logic [7:0]  R_ram_wdata;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;

    text_writer dut (
        .R_clk_65M  (clk),
        .rst        (rst),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .R_ram_we   (R_ram_we),
        .R_ram_waddr(R_ram_waddr),
        .R_ram_wdata(R_ram_wdata),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int d;
        int c;
    } wr_t;

    wr_t wq[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  rdy_we = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (R_ram_we) begin
            wq.push_back('{a: int'(R_ram_waddr), d: int'(R_ram_wdata), c: cyc});
            if (char_ready) rdy_we++;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int wa(input int i);
        if (i < wq.size()) return wq[i].a;
        return -1;
    endfunction

    function automatic int wd(input int i);
        if (i < wq.size()) return wq[i].d;
        return -1;
    endfunction

    function automatic int wc(input int i);
        if (i < wq.size()) return wq[i].c;
        return -1;
    endfunction

    task automatic send(input logic [7:0] c);
        @(negedge clk);
        char_valid = 1'b1;
        char_data  = c;
        for (int i = 0; i < 5000; i++) begin
            if (char_ready) begin
                @(posedge clk);
                #1;
                char_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        chk("send_timeout", 0, 1);
        char_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!char_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!char_ready) chk("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_blank_run(input string tag, input int first, input int base, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (wa(first + i) != base + i || wd(first + i) != 32) bad++;
        end
        chk(tag, bad, 0);
    endtask

    task automatic chk_cur(input string tag, input int col, input int row);
        chk({tag, "_col"}, int'(cursor_col), col);
        chk({tag, "_row"}, int'(cursor_row), row);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", int'(char_ready), 0);
        chk("rst_we", int'(R_ram_we), 0);
        chk("rst_waddr", int'(R_ram_waddr), 0);
        chk("rst_wdata", int'(R_ram_wdata), 0);
        chk_cur("rst", 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", int'(char_ready), 1);

        wq.delete();
        send(8'h41);
        send(8'h42);
        wait_idle();
        chk("ab_n", wq.size(), 2);
        chk("ab_a0", wa(0), 0);
        chk("ab_d0", wd(0), 8'h41);
        chk("ab_a1", wa(1), 1);
        chk("ab_d1", wd(1), 8'h42);
        chk("ab_gap", wc(1) - wc(0), 1);
        chk_cur("ab", 2, 0);

        repeat (3) send(8'h0D);
        repeat (79) send(8'h78);
        wait_idle();
        chk_cur("pre_wrap", 79, 3);

        wq.delete();
        rdy_we = 0;
        send(8'h5A);
        wait_idle();
        chk("wrap_n", wq.size(), 81);
        chk("wrap_a0", wa(0), 319);
        chk("wrap_d0", wd(0), 8'h5A);
        chk_blank_run("wrap_clr", 1, 320, 80);
        chk("wrap_span", wc(80) - wc(0), 80);
        chk("wrap_rdy", rdy_we, 0);
        chk_cur("wrap", 0, 4);

        wq.delete();
        rdy_we = 0;
        send(8'h0C);
        wait_idle();
        chk("ff_n", wq.size(), 3200);
        chk_blank_run("ff_clr", 0, 0, 3200);
        chk("ff_rdy", rdy_we, 0);
        chk_cur("ff", 0, 0);

        repeat (2) send(8'h0D);
        wait_idle();
        wq.delete();
        send(8'h08);
        wait_idle();
        chk("bs0_n", wq.size(), 0);
        chk_cur("bs0", 0, 2);

        repeat (4) send(8'h61);
        wait_idle();
        wq.delete();
        send(8'h08);
        wait_idle();
        chk("bs_n", wq.size(), 1);
        chk("bs_a", wa(0), 163);
        chk("bs_d", wd(0), 8'h20);
        chk_cur("bs", 3, 2);

        wq.delete();
        send(8'h01);
        wait_idle();
        chk("other_n", wq.size(), 0);
        chk_cur("other", 3, 2);

        repeat (37) send(8'h0A);
        repeat (5) send(8'h62);
        wait_idle();
        chk_cur("pre_nl", 5, 39);
        wq.delete();
        send(8'h0D);
        wait_idle();
        chk("nl_n", wq.size(), 80);
        chk_blank_run("nl_clr", 0, 0, 80);
        chk_cur("nl", 0, 0);

        send(8'h43);
        send(8'h0C);
        repeat (100) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_we", int'(R_ram_we), 0);
        chk("mid_ready", int'(char_ready), 0);
        chk("mid_waddr", int'(R_ram_waddr), 0);
        chk("mid_wdata", int'(R_ram_wdata), 0);
        chk_cur("mid", 0, 0);
        wq.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_nowr", wq.size(), 0);
        send(8'h51);
        wait_idle();
        chk("post_n", wq.size(), 1);
        chk("post_a", wa(0), 0);
        chk("post_d", wd(0), 8'h51);
        chk_cur("post", 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
